// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: default width, ALUctl opcodes,
// requester tags and the legal-opcode check.
package alu_pkg;

  localparam int unsigned XLEN_DEF = 64;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND, OR, ADD, SUB, signed SLT, NOR; other codes yield 0.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (alu_ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the loser after each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = '0;
    if (rst_n) begin
      case (eligible)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters: round-robin grant, registered
// operands, result returned on the issuer's response channel. Option: ALU_ARB_ERR_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_zero,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_zero
`ifdef ALU_ARB_ERR_EN
 ,output logic            rsp0_err,
  output logic            rsp1_err
`endif
);

  logic [1:0]      eligible;
  logic [1:0]      grant;
  logic [1:0]      land;
  logic [1:0]      rsp_ready;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_zero;
  logic [XLEN-1:0] rsp_result [2];

  logic            iss_valid;
  req_id_e         iss_id;
  logic [3:0]      iss_op;
  logic [XLEN-1:0] iss_a;
  logic [XLEN-1:0] iss_b;

  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic [XLEN-1:0] wr_result;
  logic            wr_zero;

  // A full response slot may still accept a new request if it drains on this edge.
  assign eligible[0] = req0_valid & (~rsp_valid[0] | rsp0_ready)
                     & ~(iss_valid & (iss_id == REQ0));
  assign eligible[1] = req1_valid & (~rsp_valid[1] | rsp1_ready)
                     & ~(iss_valid & (iss_id == REQ1));

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .grant    (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_id    <= REQ0;
      iss_op    <= '0;
      iss_a     <= '0;
      iss_b     <= '0;
    end else begin
      iss_valid <= |grant;
      if (grant[1]) begin
        iss_id <= REQ1;
        iss_op <= req1_op;
        iss_a  <= req1_a;
        iss_b  <= req1_b;
      end else if (grant[0]) begin
        iss_id <= REQ0;
        iss_op <= req0_op;
        iss_a  <= req0_a;
        iss_b  <= req0_b;
      end
    end
  end

`ifdef ALU_ARB_ERR_EN
  logic       wr_err;
  logic [1:0] rsp_err;

  // Illegal opcodes bypass the ALU with quiet operands and a forced zero result.
  assign wr_err    = ~is_legal_op(iss_op);
  assign alu_op    = wr_err ? ALU_AND : iss_op;
  assign alu_a     = wr_err ? '0 : iss_a;
  assign alu_b     = wr_err ? '0 : iss_b;
  assign wr_result = wr_err ? '0 : alu_result;
  assign wr_zero   = wr_err | alu_zero;
`else
  assign alu_op    = iss_op;
  assign alu_a     = iss_a;
  assign alu_b     = iss_b;
  assign wr_result = alu_result;
  assign wr_zero   = alu_zero;
`endif

  alu #(.XLEN(XLEN)) u_alu (
    .alu_ctl (alu_op),
    .a       (alu_a),
    .b       (alu_b),
    .result  (alu_result),
    .zero    (alu_zero)
  );

  assign land[0]   = iss_valid & (iss_id == REQ0);
  assign land[1]   = iss_valid & (iss_id == REQ1);
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A landing result takes priority over the drain so valid stays high on refill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_zero  <= '0;
`ifdef ALU_ARB_ERR_EN
      rsp_err   <= '0;
`endif
      for (int unsigned i = 0; i < 2; i++) begin
        rsp_result[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (land[i]) begin
          rsp_valid[i]  <= 1'b1;
          rsp_result[i] <= wr_result;
          rsp_zero[i]   <= wr_zero;
`ifdef ALU_ARB_ERR_EN
          rsp_err[i]    <= wr_err;
`endif
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp0_result = rsp_result[0];
  assign rsp1_result = rsp_result[1];
  assign rsp0_zero   = rsp_zero[0];
  assign rsp1_zero   = rsp_zero[1];
`ifdef ALU_ARB_ERR_EN
  assign rsp0_err    = rsp_err[0];
  assign rsp1_err    = rsp_err[1];
`endif

endmodule
